// File: rtl/spad_ring_ctrl.sv
// rtl/spad_ring_ctrl.sv - scratchpad ring-buffer FIFO controller; SPAD_CTRL_WATERMARK_EN adds peak_count
module spad_ring_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int PAR_WRITE  = 2,
   parameter int PAR_READ   = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [PAR_WRITE*DATA_WIDTH-1:0]  in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [PAR_READ*DATA_WIDTH-1:0]   out_data,
   output logic                             sp_wen,
   output logic [ADDR_WIDTH-1:0]            sp_waddr,
   output logic [PAR_WRITE*DATA_WIDTH-1:0]  sp_din,
   output logic [ADDR_WIDTH-1:0]            sp_raddr,
   input  logic [PAR_READ*DATA_WIDTH-1:0]   sp_dout,
   output logic [ADDR_WIDTH:0]              count
`ifdef SPAD_CTRL_WATERMARK_EN
   ,
   output logic [ADDR_WIDTH:0]              peak_count
`endif
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   PW_C    = (ADDR_WIDTH+1)'(PAR_WRITE);
   localparam logic [ADDR_WIDTH:0]   PR_C    = (ADDR_WIDTH+1)'(PAR_READ);
   // Pointer steps modulo DEPTH; a step equal to DEPTH wraps to zero.
   localparam logic [ADDR_WIDTH-1:0] PW_STEP = ADDR_WIDTH'(PAR_WRITE % DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PR_STEP = ADDR_WIDTH'(PAR_READ % DEPTH);

   // Aligned, non-straddling bursts need DEPTH to be a multiple of both group sizes.
   generate
      if ((PAR_WRITE < 1) || (PAR_READ < 1) || (PAR_WRITE > DEPTH) || (PAR_READ > DEPTH) ||
          ((DEPTH % PAR_WRITE) != 0) || ((DEPTH % PAR_READ) != 0)) begin : g_bad_cfg
         $fatal(1, "spad_ring_ctrl: DEPTH must be a multiple of PAR_WRITE and PAR_READ");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_next;
   logic [ADDR_WIDTH:0]   space;
   logic                  push;
   logic                  pop;

   // Handshakes from registered occupancy only; same-cycle pops never free room for a push.
   always_comb begin
      space      = DEPTH_C - count_q;
      in_ready   = rst_n & ~flush & (space >= PW_C);
      out_valid  = rst_n & ~flush & (count_q >= PR_C);
      push       = in_valid & in_ready;
      pop        = out_valid & out_ready;
      count_next = count_q + (push ? PW_C : '0) - (pop ? PR_C : '0);
   end

   assign sp_wen   = push;
   assign sp_waddr = wptr;
   assign sp_din   = in_data;
   assign sp_raddr = rptr;
   assign out_data = sp_dout;
   assign count    = count_q;

   // Pointer and occupancy registers; reset and flush both drop everything held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else if (flush) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr <= wptr + PW_STEP;
         if (pop)  rptr <= rptr + PR_STEP;
         count_q <= count_next;
      end
   end

`ifdef SPAD_CTRL_WATERMARK_EN
   // High-water mark of occupancy since the last reset or flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_count <= '0;
      end else if (flush) begin
         peak_count <= '0;
      end else if (count_next > peak_count) begin
         peak_count <= count_next;
      end
   end
`endif

endmodule

// File: tb/tb_spad_ring_ctrl.sv
// tb/tb_spad_ring_ctrl.sv - table-driven bench for spad_ring_ctrl
module tb_spad_ring_ctrl;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int PW = 2;
   localparam int PR = 1;
   localparam int NV = 28;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [PW*DW-1:0] in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [PR*DW-1:0] out_data;
   logic           sp_wen;
   logic [AW-1:0]  sp_waddr;
   logic [PW*DW-1:0] sp_din;
   logic [AW-1:0]  sp_raddr;
   logic [PR*DW-1:0] sp_dout;
   logic [AW:0]    count;
`ifdef SPAD_CTRL_WATERMARK_EN
   logic [AW:0]    peak_count;
`endif

   logic [DW-1:0]  mem [0:15];

   int vectors = 0;
   int miscompares = 0;

   spad_ring_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sp_wen(sp_wen), .sp_waddr(sp_waddr), .sp_din(sp_din),
      .sp_raddr(sp_raddr), .sp_dout(sp_dout), .count(count)
`ifdef SPAD_CTRL_WATERMARK_EN
      , .peak_count(peak_count)
`endif
   );

   always #5 clk = ~clk;

   // Scratchpad: synchronous write, combinational read
   always @(posedge clk) begin
      if (sp_wen) begin
         for (int i = 0; i < PW; i++) mem[int'(sp_waddr) + i] <= sp_din[DW*i +: DW];
      end
   end
   assign sp_dout = mem[sp_raddr];

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        iv;
      logic [31:0] din;
      logic        ord;
      logic        ir;
      logic        ov;
      logic [15:0] od;
      logic        wen;
      logic [2:0]  wa;
      logic [2:0]  ra;
      logic [3:0]  cnt;
      logic [3:0]  pk;
   } vec_t;

   vec_t vt [NV];

   function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] din,
                               input logic ord, input logic ir, input logic ov, input logic [15:0] od,
                               input logic wen, input logic [2:0] wa, input logic [2:0] ra,
                               input logic [3:0] cnt, input logic [3:0] pk);
      vec_t v;
      v.rst_n = r; v.flush = f; v.iv = iv; v.din = din; v.ord = ord;
      v.ir = ir; v.ov = ov; v.od = od; v.wen = wen; v.wa = wa; v.ra = ra; v.cnt = cnt; v.pk = pk;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
      end
   endtask

   int sent, got, exp_w, exp_r, exp_cnt, cyc;

   initial begin
      //            rst fl iv din           ord  ir ov od        wen wa ra cnt pk
      vt[0]  = mk(0, 0, 0, 32'h0,        0,   0, 0, 16'h0,    0, 0, 0, 0, 0);
      vt[1]  = mk(1, 0, 1, 32'h00020001, 0,   1, 0, 16'h0,    1, 0, 0, 0, 0);
      vt[2]  = mk(1, 0, 0, 32'h0,        1,   1, 1, 16'h0001, 0, 2, 0, 2, 2);
      vt[3]  = mk(1, 0, 0, 32'h0,        1,   1, 1, 16'h0002, 0, 2, 1, 1, 2);
      vt[4]  = mk(1, 0, 0, 32'h0,        0,   1, 0, 16'h0,    0, 2, 2, 0, 2);
      vt[5]  = mk(1, 0, 1, 32'h00110010, 0,   1, 0, 16'h0,    1, 2, 2, 0, 2);
      vt[6]  = mk(1, 0, 1, 32'h00130012, 0,   1, 1, 16'h0010, 1, 4, 2, 2, 2);
      vt[7]  = mk(1, 0, 1, 32'h00150014, 0,   1, 1, 16'h0010, 1, 6, 2, 4, 4);
      vt[8]  = mk(1, 0, 1, 32'h00170016, 0,   1, 1, 16'h0010, 1, 0, 2, 6, 6);
      vt[9]  = mk(1, 0, 1, 32'h00190018, 0,   0, 1, 16'h0010, 0, 2, 2, 8, 8);
      vt[10] = mk(1, 0, 1, 32'h00190018, 1,   0, 1, 16'h0010, 0, 2, 2, 8, 8);
      vt[11] = mk(1, 0, 1, 32'h00190018, 1,   0, 1, 16'h0011, 0, 2, 3, 7, 8);
      vt[12] = mk(1, 0, 1, 32'h00190018, 1,   1, 1, 16'h0012, 1, 2, 4, 6, 8);
      vt[13] = mk(1, 0, 0, 32'h0,        0,   0, 1, 16'h0013, 0, 4, 5, 7, 8);
      vt[14] = mk(1, 0, 0, 32'h0,        1,   0, 1, 16'h0013, 0, 4, 5, 7, 8);
      vt[15] = mk(1, 0, 0, 32'h0,        1,   1, 1, 16'h0014, 0, 4, 6, 6, 8);
      vt[16] = mk(1, 1, 1, 32'hdeadbeef, 1,   0, 0, 16'h0,    0, 4, 7, 5, 8);
      vt[17] = mk(1, 0, 0, 32'h0,        0,   1, 0, 16'h0,    0, 0, 0, 0, 0);
      vt[18] = mk(1, 0, 1, 32'h00210020, 0,   1, 0, 16'h0,    1, 0, 0, 0, 0);
      vt[19] = mk(1, 0, 1, 32'h00230022, 0,   1, 1, 16'h0020, 1, 2, 0, 2, 2);
      vt[20] = mk(1, 0, 1, 32'h00250024, 0,   1, 1, 16'h0020, 1, 4, 0, 4, 4);
      vt[21] = mk(1, 0, 1, 32'h00270026, 1,   1, 1, 16'h0020, 1, 6, 0, 6, 6);
      vt[22] = mk(1, 0, 0, 32'h0,        1,   0, 1, 16'h0021, 0, 0, 1, 7, 7);
      vt[23] = mk(1, 0, 1, 32'h00290028, 1,   1, 1, 16'h0022, 1, 0, 2, 6, 7);
      vt[24] = mk(1, 0, 0, 32'h0,        1,   0, 1, 16'h0023, 0, 2, 3, 7, 7);
      vt[25] = mk(1, 0, 0, 32'h0,        1,   1, 1, 16'h0024, 0, 2, 4, 6, 7);
      vt[26] = mk(0, 0, 1, 32'h12345678, 1,   0, 0, 16'h0,    0, 2, 5, 5, 7);
      vt[27] = mk(1, 0, 0, 32'h0,        0,   1, 0, 16'h0,    0, 0, 0, 0, 0);

      @(posedge clk);

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         rst_n     = vt[k].rst_n;
         flush     = vt[k].flush;
         in_valid  = vt[k].iv;
         in_data   = vt[k].din;
         out_ready = vt[k].ord;
         #1;
         vectors++;
         chk("in_ready",  k, 32'(in_ready),  32'(vt[k].ir));
         chk("out_valid", k, 32'(out_valid), 32'(vt[k].ov));
         if (vt[k].ov) chk("out_data", k, 32'(out_data), 32'(vt[k].od));
         chk("sp_wen",    k, 32'(sp_wen),    32'(vt[k].wen));
         chk("sp_waddr",  k, 32'(sp_waddr),  32'(vt[k].wa));
         chk("sp_raddr",  k, 32'(sp_raddr),  32'(vt[k].ra));
         chk("count",     k, 32'(count),     32'(vt[k].cnt));
         if (vt[k].wen) chk("sp_din", k, 32'(sp_din), vt[k].din);
`ifdef SPAD_CTRL_WATERMARK_EN
         chk("peak_count", k, 32'(peak_count), 32'(vt[k].pk));
`endif
      end

      // Streaming with random handshakes: order, pointer wrap and occupancy
      @(negedge clk);
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sent = 0; got = 0; exp_w = 0; exp_r = 0; exp_cnt = 0; cyc = 0;
      while (got < 40 && cyc < 2000) begin
         in_valid  = (sent < 20) && ($urandom_range(0, 1) == 1);
         in_data   = {16'(2*sent + 1), 16'(2*sent)};
         out_ready = ($urandom_range(0, 1) == 1);
         #1;
         vectors++;
         chk("stream_count", cyc, 32'(count), 32'(exp_cnt));
         if (in_valid && in_ready) begin
            chk("stream_waddr", sent, 32'(sp_waddr), 32'(exp_w));
            sent++;
            exp_w = (exp_w + PW) % 8;
            exp_cnt += PW;
         end
         if (out_valid && out_ready) begin
            chk("stream_data",  got, 32'(out_data), 32'(got));
            chk("stream_raddr", got, 32'(sp_raddr), 32'(exp_r));
            got++;
            exp_r = (exp_r + PR) % 8;
            exp_cnt -= PR;
         end
         @(negedge clk);
         cyc++;
      end
      vectors++;
      chk("stream_done", cyc, 32'(got), 32'd40);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      vectors++;
      chk("stream_end_count", 0, 32'(count), 32'd0);
      chk("stream_end_valid", 0, 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spad_ring_ctrl.md
# spad_ring_ctrl

Ring-buffer controller that sequences the register-file scratchpad (RSP) as a streaming FIFO. It accepts PAR_WRITE-word bursts on a valid/ready input, drives the scratchpad write port, and presents PAR_READ-word groups on a valid/ready output. Read data comes from the scratchpad's combinational read port. It sits between a producer stage, such as a line or filter loader, and a consumer stage, such as a PE array feeder, and owns all scratchpad addressing.

## Interface
Parameters:
- DATA_WIDTH, 16: bits per scratchpad word.
- ADDR_WIDTH, 3: scratchpad address width. DEPTH = 2**ADDR_WIDTH.
- PAR_WRITE, 2: words written per accepted input beat.
- PAR_READ, 1: words delivered per accepted output beat.

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of pointers and occupancy.
- in_valid  in  1  producer has a burst.
- in_ready  out  1  controller accepts a burst this cycle.
- in_data  in  PAR_WRITE*DATA_WIDTH  burst; word i in bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
- out_valid  out  1  a PAR_READ group is available.
- out_ready  in  1  consumer takes the group.
- out_data  out  PAR_READ*DATA_WIDTH  group; word 0 is the oldest.
- sp_wen  out  1  scratchpad write enable.
- sp_waddr  out  ADDR_WIDTH  scratchpad write base address.
- sp_din  out  PAR_WRITE*DATA_WIDTH  scratchpad write data.
- sp_raddr  out  ADDR_WIDTH  scratchpad read base address.
- sp_dout  in  PAR_READ*DATA_WIDTH  scratchpad read data (combinational from sp_raddr).
- count  out  ADDR_WIDTH+1  words currently held, 0..DEPTH.

## Operation
- Legal configurations:
  - DEPTH must be an integer multiple of both PAR_WRITE and PAR_READ.
  - Illegal configurations are rejected at elaboration.
- Pointer alignment and wrap:
  - wptr advances by PAR_WRITE and rptr by PAR_READ, each modulo DEPTH.
  - Every access is therefore aligned, and no burst ever straddles address DEPTH-1 to 0. The scratchpad does not wrap internally.
- Push:
  - push = in_valid & in_ready.
  - in_ready = rst_n & ~flush & (DEPTH - count >= PAR_WRITE).
  - On push: sp_wen=1, sp_waddr=wptr, sp_din=in_data. sp_wen is otherwise 0.
  - sp_din mirrors in_data at all times.
- Pop:
  - pop = out_valid & out_ready.
  - out_valid = rst_n & ~flush & (count >= PAR_READ).
  - sp_raddr=rptr and out_data=sp_dout, continuously.
- Occupancy update:
  - count_next = count + (push ? PAR_WRITE : 0) - (pop ? PAR_READ : 0).
  - Push and pop in the same cycle are both honoured.
  - There is no pass-through: in_ready is computed from the registered count only, so a same-cycle pop does not free space for a same-cycle push.
- Flush:
  - Priority: rst_n low > flush > push/pop.
  - Flush forces wptr=rptr=count=0, sp_wen=0, in_ready=0 and out_valid=0 in that cycle.
  - Scratchpad contents are not cleared. Stale words are unreachable because count=0.
- Reset: identical effect to flush. Applies mid-burst with no partial-state retention.
- States: EMPTY (count<PAR_READ), ACTIVE, FULL (DEPTH-count<PAR_WRITE). These are derived from count, with no separate state register. Transitions occur only through push, pop, flush or reset.

## Timing
- Reset values: count=0, sp_wen=0, sp_waddr=0, sp_raddr=0, out_valid=0, in_ready=0 while rst_n=0. in_ready=1 in the first cycle after release.
- Latency: a word pushed at edge N is visible on out_data, with out_valid=1, in the cycle after edge N. This gives 1-cycle fill latency.
- Throughput: with PAR_WRITE >= PAR_READ, sustained full-rate output is one group per cycle once primed.
- Handshake rules:
  - in_ready and out_valid are combinational from registered state plus rst_n/flush only.
  - Neither depends on in_valid or out_ready.
  - Data held while valid and not ready must remain stable on out_data.

## Configuration
- SPAD_CTRL_WATERMARK_EN
  - Defined: adds output peak_count [ADDR_WIDTH:0]. It is a register holding the maximum count_next seen since the last reset or flush, reset to 0, updated each cycle as max(peak_count, count_next).
  - Undefined: the port and register do not exist. All other behaviour is identical.

## Test plan
Defaults DEPTH=8, PAR_WRITE=2, PAR_READ=1.
- Reset, then push in_data=0x0002_0001 -> next cycle count=2, out_valid=1, out_data=0x0001. After one pop, out_data=0x0002. After a second pop, count=0 and out_valid=0.
- Four pushes with out_ready=0 -> count=8, in_ready=0, sp_wen=0. A fifth in_valid is held with no write. Pop once -> count=7, in_ready stays 0. Pop again -> count=6, in_ready=1.
- count=6, push and pop in the same cycle -> count=7, sp_waddr=6 on the write, sp_raddr advances by 1.
- Stream 40 incrementing words with random in_valid/out_ready -> output order exactly 0..39. wptr wraps 6->0 and rptr wraps 7->0 with no write to address 8.
- count=5 with flush asserted alongside in_valid and out_ready -> sp_wen=0 that cycle. Next cycle count=0, out_valid=0, sp_raddr=0, sp_waddr=0.
- rst_n low for one cycle at count=5 mid-stream -> same as flush. Under SPAD_CTRL_WATERMARK_EN, peak_count=8 after the fill scenario and 0 after reset.
